// File: rtl/rca_bist.sv
// rca_bist: exhaustive self-test engine for a WIDTH-bit ripple-carry adder.
// Optional build macro RCA_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module rca_bist #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 cin_out,
  input  logic [WIDTH-1:0]     sum_in,
  input  logic                 cout_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [2*WIDTH:0]     first_fail
);

  localparam int VW = 2*WIDTH + 1;
  localparam logic [VW-1:0] VLast = {VW{1'b1}};

`ifdef RCA_BIST_STOP_ON_FAIL_EN
  localparam bit StopOnFail = 1'b1;
`else
  localparam bit StopOnFail = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [VW-1:0]   vec_q;
  logic [15:0]     errCount_q;
  logic [15:0]     errCount_d;
  logic [VW-1:0]   firstFail_q;
  logic            pass_q;
  logic            busy_q;
  logic            done_q;

  logic [WIDTH:0]  golden;
  logic            mismatch;

  // The adder under test sees the held vector, so the response is compared
  // against the golden sum of the same vector one cycle after it settles.
  always_comb begin
    golden   = {1'b0, vec_q[2*WIDTH-1:WIDTH]} + {1'b0, vec_q[WIDTH-1:0]}
             + {{WIDTH{1'b0}}, vec_q[2*WIDTH]};
    mismatch = ({cout_in, sum_in} != golden);
    errCount_d = (errCount_q == 16'hFFFF) ? errCount_q : errCount_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      errCount_q  <= '0;
      firstFail_q <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= DRIVE;
            vec_q       <= '0;
            errCount_q  <= '0;
            firstFail_q <= '0;
            pass_q      <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        DRIVE: begin
          state_q <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            errCount_q <= errCount_d;
            pass_q     <= 1'b0;
            // A zero count means no earlier mismatch; saturation never wraps back to zero.
            if (errCount_q == 16'd0) begin
              firstFail_q <= vec_q;
            end
          end
          if (vec_q == VLast || (StopOnFail && mismatch)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= DRIVE;
            vec_q   <= vec_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_out      = vec_q[2*WIDTH-1:WIDTH];
  assign b_out      = vec_q[WIDTH-1:0];
  assign cin_out    = vec_q[2*WIDTH];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = errCount_q;
  assign first_fail = firstFail_q;

endmodule

// File: tb/tb_rca_bist.sv
// tb_rca_bist: drives rca_bist against a behavioural adder with selectable faults
// and checks every sweep result against a vector-by-vector reference model.
module tb_rca_bist;

  localparam int W = 4;
  localparam int N = 1 << (2*W + 1);

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a_out;
  logic [W-1:0]   b_out;
  logic           cin_out;
  logic [W-1:0]   sum_in;
  logic           cout_in;
  logic           busy;
  logic           done;
  logic           pass;
  logic [15:0]    err_count;
  logic [2*W:0]   first_fail;

  int             checks;
  int             errors;
  int             faultMode;
  logic [W:0]     flipTab [N];

  rca_bist #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_out      (a_out),
    .b_out      (b_out),
    .cin_out    (cin_out),
    .sum_in     (sum_in),
    .cout_in    (cout_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder under test: mode 0 golden, 1 cout stuck at 0, 2 sum[0] inverted,
  // 3 random response corruption taken from flipTab.
  function automatic logic [W:0] respFor(input int mode, input int a, input int b,
                                         input int cin, input logic [W:0] flip);
    logic [W:0] r;
    r = (W+1)'(a + b + cin);
    case (mode)
      1: r[W] = 1'b0;
      2: r[0] = ~r[0];
      3: r = r ^ flip;
      default: ;
    endcase
    return r;
  endfunction

  assign {cout_in, sum_in} = respFor(faultMode, int'(a_out), int'(b_out), int'(cin_out),
                                     flipTab[{cin_out, a_out, b_out}]);

  // Reference: walk the vector space in arithmetic order and tally mismatches.
  task automatic modelRun(output int expErr, output int expFf, output int expPass,
                          output int expLat, output int expLastV);
    int a, b, cin, g;
    expErr = 0; expFf = 0; expLat = 2*N; expLastV = N - 1;
    for (int v = 0; v < N; v++) begin
      cin = v / (1 << (2*W));
      a   = (v / (1 << W)) % (1 << W);
      b   = v % (1 << W);
      g   = a + b + cin;
      if (int'(respFor(faultMode, a, b, cin, flipTab[v])) != g) begin
        if (expErr == 0) expFf = v;
        expErr++;
`ifdef RCA_BIST_STOP_ON_FAIL_EN
        expLat = 2*(v + 1);
        expLastV = v;
        break;
`endif
      end
    end
    expPass = (expErr == 0) ? 1 : 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse start, then count edges from the start edge until done (bounded).
  task automatic applyStimulus(input int extraStartAt, output int latency, output bit busyOk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    latency = 0;
    busyOk = (busy === 1'b1);
    while (done !== 1'b1 && latency < 4*N) begin
      @(posedge clk);
      #1;
      latency++;
      if (done !== 1'b1 && busy !== 1'b1) busyOk = 1'b0;
      start = (latency == extraStartAt);
    end
    start = 1'b0;
  endtask

  task automatic sweepAndCheck(input string name, input int mode, input int extraStartAt);
    int lat, eErr, eFf, ePass, eLat, eLast;
    bit busyOk;
    faultMode = mode;
    modelRun(eErr, eFf, ePass, eLat, eLast);
    applyStimulus(extraStartAt, lat, busyOk);
    checkOutput({name, "_latency"}, lat, eLat);
    checkOutput({name, "_busyHeld"}, 32'(busyOk), 32'd1);
    checkOutput({name, "_done"}, 32'(done), 32'd1);
    checkOutput({name, "_busyOff"}, 32'(busy), 32'd0);
    checkOutput({name, "_pass"}, 32'(pass), 32'(ePass));
    checkOutput({name, "_errCount"}, 32'(err_count), 32'(eErr));
    if (ePass == 0) checkOutput({name, "_firstFail"}, 32'(first_fail), 32'(eFf));
    checkOutput({name, "_lastVec"}, {23'd0, cin_out, a_out, b_out}, 32'(eLast));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    faultMode = 0;
    start = 1'b0;
    rst_n = 1'b0;
    for (int v = 0; v < N; v++) flipTab[v] = '0;

    #12;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_pass", 32'(pass), 32'd0);
    checkOutput("reset_err", 32'(err_count), 32'd0);
    checkOutput("reset_vec", {23'd0, cin_out, a_out, b_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    sweepAndCheck("golden", 0, -1);
    checkOutput("golden_a", 32'(a_out), 32'd15);
    checkOutput("golden_b", 32'(b_out), 32'd15);
    checkOutput("golden_cin", 32'(cin_out), 32'd1);

    sweepAndCheck("coutStuck", 1, -1);
`ifndef RCA_BIST_STOP_ON_FAIL_EN
    checkOutput("coutStuck_err256", 32'(err_count), 32'd256);
    checkOutput("coutStuck_ff01F", 32'(first_fail), 32'h01F);
`endif

    sweepAndCheck("sum0Inv", 2, -1);
    checkOutput("sum0Inv_ff0", 32'(first_fail), 32'd0);

    // Second start from DONE after a failing run must clear all results.
    sweepAndCheck("rerunGolden", 0, -1);

    for (int v = 0; v < N; v++)
      flipTab[v] = ($urandom_range(0, 7) == 0) ? (W+1)'($urandom_range(1, (1 << (W+1)) - 1)) : '0;
    sweepAndCheck("randomFault", 3, -1);

    sweepAndCheck("extraStart", 0, 100);

    // Asynchronous reset in the middle of a sweep, checked before any further clock edge.
    faultMode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset_busy", 32'(busy), 32'd0);
    checkOutput("midReset_done", 32'(done), 32'd0);
    checkOutput("midReset_pass", 32'(pass), 32'd0);
    checkOutput("midReset_err", 32'(err_count), 32'd0);
    checkOutput("midReset_ff", 32'(first_fail), 32'd0);
    checkOutput("midReset_vec", {23'd0, cin_out, a_out, b_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweepAndCheck("postReset", 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_bist.md
# rca_bist

Self-test engine for the ripple-carry adder. It drives every input combination into an adder under test and checks each `sum`/`cout` response against an internal golden sum. It reports pass/fail, the number of errors and the first failing vector. It is the hardware counterpart of the exhaustive adder bench: it generates the stimulus and acts as the receiving-end response checker beside the adder in the datapath.

## Interface
Parameters:
- `WIDTH`, 4: adder operand width. The vector space is N = 2^(2*WIDTH+1).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE
- `a_out`  out  WIDTH  operand A to the adder under test
- `b_out`  out  WIDTH  operand B to the adder under test
- `cin_out`  out  1  carry-in to the adder under test
- `sum_in`  in  WIDTH  sum returned by the adder under test
- `cout_in`  in  1  carry-out returned by the adder under test
- `busy`  out  1  sweep in progress
- `done`  out  1  sweep finished; a level, held until the next start
- `pass`  out  1  valid when done=1; 1 means no mismatches
- `err_count`  out  16  mismatch count; saturates at 16'hFFFF
- `first_fail`  out  2*WIDTH+1  index of the first mismatching vector; valid when done=1 and pass=0

## Operation
- Vector index v, 2*WIDTH+1 bits, split as {cin, a, b}:
  - cin = v[2W]
  - a = v[2W-1:W]
  - b = v[W-1:0]
  - b varies fastest, then a, then cin. This is the same order as the bench sweep.
- Golden value exp = a + b + cin, computed at WIDTH+1 bits.
- Mismatch when {cout_in, sum_in} != exp.
- FSM states:
  - IDLE: busy=0, done=0. start=1 → DRIVE; v=0; err_count and first_fail cleared; pass=1.
  - DRIVE: present vector v → CHECK unconditionally.
  - CHECK: compare. On mismatch, increment err_count (saturating) and clear pass. If this is the first mismatch, capture first_fail=v. If v = N-1 → DONE; otherwise v+1 → DRIVE.
  - DONE: busy=0, done=1, results held. start=1 → same action as from IDLE.
- start in DRIVE or CHECK is ignored.
- a_out/b_out/cin_out are registered. They are held stable across DRIVE and CHECK, so a purely combinational adder has one full cycle to settle.
- Output values in IDLE or DONE:
  - After reset: all zero.
  - After a sweep: the last vector is held.

## Timing
- Reset (async, immediate) sets the following, in any state, including mid-sweep:
  - state=IDLE
  - a_out=b_out=cin_out=0, v=0
  - busy=0, done=0, pass=0
  - err_count=0, first_fail=0
  - No partial results survive reset.
- Start edge E0 (start=1 sampled) → busy=1 and vector 0 on the outputs after E0.
- Vector k is driven after edge E(2k) and checked at edge E(2k+1)…

Correction to the timing above: the edge sequence is as follows.
- Start edge E0 → DRIVE, vector 0 driven.
- E1 → CHECK.
- E2 samples sum_in/cout_in for vector 0 and drives vector 1.
- Generally, vector k is driven from E(2k) and its response is sampled at E(2k+2).
- After the check of vector N-1 at E(2N): done=1, busy=0.
- Total latency is 2N cycles. For WIDTH=4: N=512, so done rises after E1024.
- err_count, pass and first_fail update on the same edge as the check that causes them.
- A simultaneous start and final check cannot occur, because start is ignored while busy.

## Configuration
- `RCA_BIST_STOP_ON_FAIL_EN` defined:
  - The first mismatch in CHECK moves directly to DONE.
  - err_count=1, pass=0, first_fail=v.
  - Latency is 2*(first_fail+1) cycles.
- Not defined: the full sweep always runs, and all mismatches are counted.

## Test plan
- Golden behavioural adder attached, WIDTH=4, start pulse:
  - done after 1024 cycles, busy high throughout.
  - pass=1, err_count=0.
  - Final outputs a_out=15, b_out=15, cin_out=1.
- Adder with cout stuck at 0:
  - err_count=256 (120 with cin=0, 136 with cin=1).
  - pass=0, first_fail=9'h01F (cin=0, a=1, b=15).
- Adder with sum[0] inverted:
  - err_count=512, first_fail=0, pass=0.
  - With `RCA_BIST_STOP_ON_FAIL_EN`: done 2 cycles after start, err_count=1.
- rst_n low at cycle 300 of a sweep:
  - All outputs 0 immediately, without waiting for a clock.
  - After release, a new start gives a clean full run: 1024 cycles, pass=1.
- Extra start pulse at cycle 100 of a sweep:
  - Ignored; done still at cycle 1024.
- A second start from DONE after a failing run, with the golden adder:
  - err_count cleared, pass=1 at completion.
